// File: rtl/accel_divider_core_pkg.sv
// Shared definitions for the divider engine and the register-file slave it serves.
package accel_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        HOLD = 2'd3
    } state_e;

    localparam int ST_DIVZ     = 0;
    localparam int ST_OVF      = 1;
    localparam int ST_BUSY     = 2;
    localparam int CTRL_SIGNED = 0;
    localparam int DONE_BIT    = 31;
    localparam int START_BIT   = 0;

    // Slave register 0 as software sees it: START written by the host, DONE from the engine.
    function automatic logic [31:0] reg0_view(input logic start, input logic done);
        logic [31:0] word;
        word            = '0;
        word[START_BIT] = start;
        word[DONE_BIT]  = done;
        return word;
    endfunction

endpackage

// File: rtl/accel_divider_core_if.sv
// Level/register bundle between the Avalon register-file slave and the divider engine.
interface accel_divider_core_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  START;
    logic [DATA_WIDTH-1:0] OPERAND_A;
    logic [DATA_WIDTH-1:0] OPERAND_B;
    logic [DATA_WIDTH-1:0] CTRL;
    logic                  DONE;
    logic [DATA_WIDTH-1:0] QUOTIENT;
    logic [DATA_WIDTH-1:0] REMAINDER;
    logic [DATA_WIDTH-1:0] STATUS;

    modport master (
        output START, OPERAND_A, OPERAND_B, CTRL,
        input  DONE, QUOTIENT, REMAINDER, STATUS
    );

    modport slave (
        input  START, OPERAND_A, OPERAND_B, CTRL,
        output DONE, QUOTIENT, REMAINDER, STATUS
    );
endinterface

// File: rtl/accel_div_step.sv
// One restoring-division iteration: shift {rem, quo} left, trial-subtract, keep if no borrow.
module accel_div_step #(
    parameter int DATA_WIDTH = 32
) (
    input  logic [DATA_WIDTH-1:0] rem_i,
    input  logic [DATA_WIDTH-1:0] quo_i,
    input  logic [DATA_WIDTH-1:0] divisor_i,
    output logic [DATA_WIDTH-1:0] rem_o,
    output logic [DATA_WIDTH-1:0] quo_o
);
    logic [DATA_WIDTH:0] shifted;
    logic [DATA_WIDTH:0] trial;

    always_comb begin
        shifted = {rem_i, quo_i[DATA_WIDTH-1]};
        trial   = shifted - {1'b0, divisor_i};
        // The extra MSB is the borrow: set only when the shifted remainder is below the divisor.
        if (!trial[DATA_WIDTH]) begin
            rem_o = trial[DATA_WIDTH-1:0];
            quo_o = {quo_i[DATA_WIDTH-2:0], 1'b1};
        end else begin
            rem_o = shifted[DATA_WIDTH-1:0];
            quo_o = {quo_i[DATA_WIDTH-2:0], 1'b0};
        end
    end
endmodule

// File: rtl/accel_divider_core.sv
// Iterative signed/unsigned restoring divider, one quotient bit per clock, driven by START/DONE levels.
module accel_divider_core
    import accel_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = $clog2(DATA_WIDTH)
) (
    input logic                 CSI_CLOCK_CLK,
    input logic                 CSI_CLOCK_RESET,
    accel_divider_core_if.slave bus
);
    localparam logic [DATA_WIDTH-1:0] MIN_VAL  = {1'b1, {(DATA_WIDTH-1){1'b0}}};
    localparam logic [CNT_WIDTH-1:0]  LAST_CNT = CNT_WIDTH'(DATA_WIDTH - 1);

    state_e                 state_q, state_d;
    logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0]  rem_q, rem_d;
    logic [DATA_WIDTH-1:0]  quo_q, quo_d;
    logic [DATA_WIDTH-1:0]  div_q, div_d;
    logic [DATA_WIDTH-1:0]  a_raw_q, a_raw_d;
    logic                   q_neg_q, q_neg_d;
    logic                   r_neg_q, r_neg_d;
    logic                   ovf_q, ovf_d;
    logic                   divz_q, divz_d;
    logic [DATA_WIDTH-1:0]  quotient_q, quotient_d;
    logic [DATA_WIDTH-1:0]  remainder_q, remainder_d;
    logic [1:0]             flags_q, flags_d;

    logic [DATA_WIDTH-1:0]  step_rem, step_quo;
    logic                   a_neg, b_neg, signed_mode;
    logic                   ctrl_unused;

    assign ctrl_unused = ^bus.CTRL;

    accel_div_step #(.DATA_WIDTH(DATA_WIDTH)) u_step (
        .rem_i     (rem_q),
        .quo_i     (quo_q),
        .divisor_i (div_q),
        .rem_o     (step_rem),
        .quo_o     (step_quo)
    );

    always_ff @(posedge CSI_CLOCK_CLK) begin
        if (CSI_CLOCK_RESET) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            rem_q       <= '0;
            quo_q       <= '0;
            div_q       <= '0;
            a_raw_q     <= '0;
            q_neg_q     <= 1'b0;
            r_neg_q     <= 1'b0;
            ovf_q       <= 1'b0;
            divz_q      <= 1'b0;
            quotient_q  <= '0;
            remainder_q <= '0;
            flags_q     <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rem_q       <= rem_d;
            quo_q       <= quo_d;
            div_q       <= div_d;
            a_raw_q     <= a_raw_d;
            q_neg_q     <= q_neg_d;
            r_neg_q     <= r_neg_d;
            ovf_q       <= ovf_d;
            divz_q      <= divz_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            flags_q     <= flags_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        rem_d       = rem_q;
        quo_d       = quo_q;
        div_d       = div_q;
        a_raw_d     = a_raw_q;
        q_neg_d     = q_neg_q;
        r_neg_d     = r_neg_q;
        ovf_d       = ovf_q;
        divz_d      = divz_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        flags_d     = flags_q;

        signed_mode = bus.CTRL[CTRL_SIGNED];
        a_neg       = signed_mode & bus.OPERAND_A[DATA_WIDTH-1];
        b_neg       = signed_mode & bus.OPERAND_B[DATA_WIDTH-1];

        case (state_q)
            IDLE: begin
                if (bus.START) begin
                    quo_d   = a_neg ? -bus.OPERAND_A : bus.OPERAND_A;
                    div_d   = b_neg ? -bus.OPERAND_B : bus.OPERAND_B;
                    rem_d   = '0;
                    cnt_d   = '0;
                    a_raw_d = bus.OPERAND_A;
                    q_neg_d = a_neg ^ b_neg;
                    r_neg_d = a_neg;
                    // MIN / -1 falls out of the magnitude path as MIN; only the flag needs recording.
                    ovf_d   = signed_mode && (bus.OPERAND_A == MIN_VAL) && (bus.OPERAND_B == '1);
                    divz_d  = (bus.OPERAND_B == '0);
                    state_d = (bus.OPERAND_B == '0) ? FIX : CALC;
                end
            end
            CALC: begin
                if (!bus.START) begin
                    state_d = IDLE;
                end else begin
                    rem_d = step_rem;
                    quo_d = step_quo;
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == LAST_CNT) begin
                        state_d = FIX;
                    end
                end
            end
            FIX: begin
                if (!bus.START) begin
                    state_d = IDLE;
                end else begin
                    if (divz_q) begin
                        quotient_d  = '1;
                        remainder_d = a_raw_q;
                        flags_d     = 2'b01;
                    end else begin
                        quotient_d  = q_neg_q ? -quo_q : quo_q;
                        remainder_d = r_neg_q ? -rem_q : rem_q;
                        flags_d     = {ovf_q, 1'b0};
                    end
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (!bus.START) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        bus.DONE              = (state_q == HOLD);
        bus.QUOTIENT          = quotient_q;
        bus.REMAINDER         = remainder_q;
        bus.STATUS            = '0;
        bus.STATUS[ST_DIVZ]   = flags_q[0];
        bus.STATUS[ST_OVF]    = flags_q[1];
        bus.STATUS[ST_BUSY]   = (state_q == CALC) || (state_q == FIX);
    end
endmodule

// File: tb/tb_accel_divider_core.sv
// Directed + randomized bench for accel_divider_core against an arithmetic reference model.
module tb_accel_divider_core;
    import accel_pkg::*;

    logic clk;
    logic srst;
    int   n_cmp;
    int   n_err;

    accel_divider_core_if #(.DATA_WIDTH(32)) bus ();

    accel_divider_core #(.DATA_WIDTH(32)) dut (
        .CSI_CLOCK_CLK   (clk),
        .CSI_CLOCK_RESET (srst),
        .bus             (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: observed no finish, expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference: truncating division computed with plain integer arithmetic.
    function automatic void ref_div(input logic [31:0] a, input logic [31:0] b, input bit sgn,
                                    output logic [31:0] q, output logic [31:0] r,
                                    output logic [31:0] st);
        int sa;
        int sb;
        if (b == 0) begin
            q = 32'hFFFF_FFFF; r = a; st = 32'd1;
        end else if (!sgn) begin
            q = a / b; r = a % b; st = 32'd0;
        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            q = 32'h8000_0000; r = 32'd0; st = 32'd2;
        end else begin
            sa = $signed(a); sb = $signed(b);
            q = sa / sb; r = sa % sb; st = 32'd0;
        end
    endfunction

    task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] ctrl, input bit scramble, input bit release_start);
        logic [31:0] eq, er, es, lat, exp_lat;
        ref_div(a, b, ctrl[0], eq, er, es);
        exp_lat       = (b == 0) ? 32'd1 : 32'd33;
        bus.OPERAND_A = a;
        bus.OPERAND_B = b;
        bus.CTRL      = ctrl;
        bus.START     = 1'b1;
        step();
        check({tag, " busy_e0"}, {31'd0, bus.STATUS[ST_BUSY]}, 32'd1);
        check({tag, " done_e0"}, {31'd0, bus.DONE}, 32'd0);
        if (scramble) begin
            bus.OPERAND_A = $urandom;
            bus.OPERAND_B = $urandom;
            bus.CTRL      = $urandom;
        end
        lat = 0;
        for (int e = 1; e <= 40; e++) begin
            step();
            if (bus.DONE) begin
                lat = e;
                break;
            end
        end
        check({tag, " latency"}, lat, exp_lat);
        check({tag, " quotient"}, bus.QUOTIENT, eq);
        check({tag, " remainder"}, bus.REMAINDER, er);
        check({tag, " status"}, bus.STATUS, es);
        $display("op %s a=%h b=%h ctrl=%h -> q=%h r=%h st=%h reg0=%h lat=%0d",
                 tag, a, b, ctrl, bus.QUOTIENT, bus.REMAINDER, bus.STATUS,
                 reg0_view(bus.START, bus.DONE), lat);
        if (release_start) begin
            bus.START = 1'b0;
            step();
            check({tag, " done_drop"}, {31'd0, bus.DONE}, 32'd0);
            check({tag, " q_persist"}, bus.QUOTIENT, eq);
        end
    endtask

    initial begin
        logic [31:0] ra, rb, rc;
        n_cmp = 0;
        n_err = 0;
        bus.START = 1'b0; bus.OPERAND_A = '0; bus.OPERAND_B = '0; bus.CTRL = '0;
        srst = 1'b1;
        step(); step();
        check("reset done", {31'd0, bus.DONE}, 32'd0);
        check("reset quotient", bus.QUOTIENT, 32'd0);
        check("reset remainder", bus.REMAINDER, 32'd0);
        check("reset status", bus.STATUS, 32'd0);
        srst = 1'b0;
        step();

        run_op("u100div7", 32'd100, 32'd7, 32'd0, 1'b0, 1'b1);
        run_op("s-100div7", 32'hFFFF_FF9C, 32'd7, 32'd1, 1'b0, 1'b1);
        run_op("umaxdivmax", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 1'b0, 1'b1);
        run_op("u55div0", 32'd55, 32'd0, 32'd0, 1'b0, 1'b1);
        run_op("sMINdivm1", 32'h8000_0000, 32'hFFFF_FFFF, 32'd1, 1'b0, 1'b1);

        // Abort mid-CALC: earlier 100 / 7 results must survive.
        run_op("u100div7b", 32'd100, 32'd7, 32'd0, 1'b0, 1'b1);
        bus.OPERAND_A = 32'd1000; bus.OPERAND_B = 32'd3; bus.START = 1'b1;
        for (int e = 0; e <= 10; e++) step();
        bus.START = 1'b0;
        step();
        check("abort busy", {31'd0, bus.STATUS[ST_BUSY]}, 32'd0);
        check("abort done", {31'd0, bus.DONE}, 32'd0);
        check("abort quotient", bus.QUOTIENT, 32'd14);
        check("abort remainder", bus.REMAINDER, 32'd2);
        for (int e = 0; e < 40; e++) step();
        check("abort done_late", {31'd0, bus.DONE}, 32'd0);
        $display("op abort q=%h r=%h st=%h", bus.QUOTIENT, bus.REMAINDER, bus.STATUS);

        // Reset in the middle of CALC wipes everything.
        bus.START = 1'b1;
        for (int e = 0; e <= 20; e++) step();
        srst = 1'b1;
        step();
        check("midreset done", {31'd0, bus.DONE}, 32'd0);
        check("midreset quotient", bus.QUOTIENT, 32'd0);
        check("midreset remainder", bus.REMAINDER, 32'd0);
        check("midreset status", bus.STATUS, 32'd0);
        srst = 1'b0;
        bus.START = 1'b0;
        step();
        $display("op midreset q=%h r=%h st=%h", bus.QUOTIENT, bus.REMAINDER, bus.STATUS);

        // START held well past completion must neither restart nor drop DONE.
        run_op("u100div7hold", 32'd100, 32'd7, 32'd0, 1'b0, 1'b0);
        for (int e = 0; e < 40; e++) begin
            step();
            if (e % 10 == 0) begin
                check("hold done", {31'd0, bus.DONE}, 32'd1);
                check("hold quotient", bus.QUOTIENT, 32'd14);
            end
        end
        bus.START = 1'b0;
        step();
        check("hold release done", {31'd0, bus.DONE}, 32'd0);
        check("hold release remainder", bus.REMAINDER, 32'd2);
        step();

        for (int i = 0; i < 30; i++) begin
            ra = $urandom;
            case ($urandom_range(0, 3))
                0: rb = 32'd0;
                1: rb = $urandom_range(1, 300);
                2: rb = -$urandom_range(1, 300);
                default: rb = $urandom;
            endcase
            rc = $urandom;
            run_op($sformatf("rnd%0d", i), ra, rb, rc, 1'b1, 1'b1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
